// File: rtl/decode_pkg.sv
// Shared opcode map, format enum and decoded-entry payload for the decode stage.
package decode_pkg;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned RAW_REG_W = 5;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_e;

   // Width-independent part of a held entry; pc/imm live beside it at XLEN.
   typedef struct packed {
      logic [6:0]           opcode;
      logic [RAW_REG_W-1:0] rd;
      logic [RAW_REG_W-1:0] rs1;
      logic [RAW_REG_W-1:0] rs2;
      logic [2:0]           funct3;
      logic [6:0]           funct7;
      fmt_e                 fmt;
      logic                 illegal;
   } decoded_t;

   // Opcode to instruction format; low bits other than 2'b11 fall to FMT_ILL.
   function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
      fmt_e f;
      case (opcode)
         OPC_OP, OPC_OP32:                             f = FMT_R;
         OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD,
         OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:           f = FMT_I;
         OPC_STORE:                                    f = FMT_S;
         OPC_BRANCH:                                   f = FMT_B;
         OPC_LUI, OPC_AUIPC:                           f = FMT_U;
         OPC_JAL:                                      f = FMT_J;
         default:                                      f = FMT_ILL;
      endcase
      return f;
   endfunction

   // True when a register field does not fit the configured index width.
   function automatic logic reg_truncated(input logic [RAW_REG_W-1:0] field,
                                          input int unsigned reg_w);
      return (field >> reg_w) != '0;
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate builder: format-selected, sign-extended to XLEN.
module imm_gen
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:7]     instr,
   input  fmt_e            fmt,
   output logic [XLEN-1:0] imm_c
);

   // Assemble the per-format immediate and sign-extend from instr[31].
   always_comb begin
      imm_c = '0;
      case (fmt)
         FMT_I:   imm_c = XLEN'($signed(instr[31:20]));
         FMT_S:   imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
         FMT_B:   imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
         FMT_U:   imm_c = XLEN'($signed({instr[31:12], 12'b0}));
         FMT_J:   imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: two-entry (output + skid) buffer with valid/ready on both sides.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [XLEN-1:0]       in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [6:0]            out_opcode,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [REG_ADDR_W-1:0] out_rs1,
   output logic [REG_ADDR_W-1:0] out_rs2,
   output logic [2:0]            out_funct3,
   output logic [6:0]            out_funct7,
   output logic [XLEN-1:0]       out_imm,
   output logic [2:0]            out_fmt,
   output logic                  out_illegal
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            in_fire;
   logic            out_fire;
   logic            ld_out_new;
   logic            ld_out_skid;
   logic            ld_skid;

   fmt_e            fmt_raw;
   fmt_e            fmt_c;
   logic            trunc_c;
   decoded_t        dec_c;
   logic [XLEN-1:0] imm_c;

   decoded_t        out_q;
   decoded_t        skid_q;
   logic [XLEN-1:0] out_pc_q;
   logic [XLEN-1:0] out_imm_q;
   logic [XLEN-1:0] skid_pc_q;
   logic [XLEN-1:0] skid_imm_q;

   assign in_ready  = (state != ST_TWO) & rst_n;
   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Field split and format classification of the incoming word.
   always_comb begin
      dec_c   = '0;
      fmt_raw = opcode_fmt(in_instr[6:0]);
      trunc_c = 1'b0;
      case (fmt_raw)
         FMT_R:        trunc_c = reg_truncated(in_instr[11:7], REG_ADDR_W)
                               | reg_truncated(in_instr[19:15], REG_ADDR_W)
                               | reg_truncated(in_instr[24:20], REG_ADDR_W);
         FMT_I:        trunc_c = reg_truncated(in_instr[11:7], REG_ADDR_W)
                               | reg_truncated(in_instr[19:15], REG_ADDR_W);
         FMT_S, FMT_B: trunc_c = reg_truncated(in_instr[19:15], REG_ADDR_W)
                               | reg_truncated(in_instr[24:20], REG_ADDR_W);
         FMT_U, FMT_J: trunc_c = reg_truncated(in_instr[11:7], REG_ADDR_W);
         default:      trunc_c = 1'b0;
      endcase
      fmt_c = trunc_c ? FMT_ILL : fmt_raw;

      dec_c.opcode  = in_instr[6:0];
      dec_c.fmt     = fmt_c;
      dec_c.illegal = (fmt_c == FMT_ILL);
      if (fmt_c inside {FMT_R, FMT_I, FMT_U, FMT_J}) dec_c.rd = in_instr[11:7];
      if (fmt_c inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
         dec_c.rs1    = in_instr[19:15];
         dec_c.funct3 = in_instr[14:12];
      end
      if (fmt_c inside {FMT_R, FMT_S, FMT_B}) dec_c.rs2 = in_instr[24:20];
      if (fmt_c == FMT_R) dec_c.funct7 = in_instr[31:25];
   end

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr (in_instr[31:7]),
      .fmt   (fmt_c),
      .imm_c (imm_c)
   );

   // Next state and register load enables; flush empties the buffer.
   always_comb begin
      state_nxt   = state;
      ld_out_new  = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt  = ST_ONE;
               ld_out_new = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               ld_out_new = 1'b1;
            end else if (out_fire) begin
               state_nxt = ST_EMPTY;
            end else if (in_fire) begin
               state_nxt = ST_TWO;
               ld_skid   = 1'b1;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               state_nxt   = ST_ONE;
               ld_out_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      if (flush) begin
         state_nxt   = ST_EMPTY;
         ld_out_new  = 1'b0;
         ld_out_skid = 1'b0;
         ld_skid     = 1'b0;
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   // Output and skid entry registers; skid drains into the output slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q      <= '0;
         out_pc_q   <= '0;
         out_imm_q  <= '0;
         skid_q     <= '0;
         skid_pc_q  <= '0;
         skid_imm_q <= '0;
      end else begin
         if (ld_out_new) begin
            out_q     <= dec_c;
            out_pc_q  <= in_pc;
            out_imm_q <= imm_c;
         end else if (ld_out_skid) begin
            out_q     <= skid_q;
            out_pc_q  <= skid_pc_q;
            out_imm_q <= skid_imm_q;
         end
         if (ld_skid) begin
            skid_q     <= dec_c;
            skid_pc_q  <= in_pc;
            skid_imm_q <= imm_c;
         end
      end
   end

   assign out_pc      = out_pc_q;
   assign out_imm     = out_imm_q;
   assign out_opcode  = out_q.opcode;
   assign out_rd      = REG_ADDR_W'(out_q.rd);
   assign out_rs1     = REG_ADDR_W'(out_q.rs1);
   assign out_rs2     = REG_ADDR_W'(out_q.rs2);
   assign out_funct3  = out_q.funct3;
   assign out_funct7  = out_q.funct7;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;

endmodule
